dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates one shared single-port data memory between two masters.
- Master 0 is the multi-cycle CPU memory-access path (sw/sb/lw/lb traffic from the MA state).
- Master 1 is a DMA/peripheral engine.
- Round-robin fairness between the masters; master 1 can hold a bounded locked burst.
- Every transaction completes with a one-cycle ack pulse, so a requester simply waits in its access state until ack.

Parameters:
- AW, 32, address width for master and memory address buses.
- DW, 32, data width.
- MAX_BURST, 4, maximum consecutive locked master-1 grants while master 0 is waiting (legal range 1..15).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 request; held with its qualifiers until m0_ack.
- m0_we  input  1  master 0 write enable (1 = write, 0 = read).
- m0_byte  input  1  master 0 byte access (lb/sb).
- m0_addr  input  AW  master 0 byte address.
- m0_wdata  input  DW  master 0 write data.
- m0_ack  output  1  one-cycle completion pulse to master 0.
- m0_rdata  output  DW  read data to master 0.
- m1_req, m1_we, m1_byte, m1_addr, m1_wdata, m1_ack, m1_rdata  same as master 0, for master 1.
- m1_lock  input  1  master 1 requests back-to-back exclusive grants.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write strobe.
- mem_byte  output  1  byte access to memory.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data; valid the cycle after mem_en.
- owner  output  1  master currently granted (valid in ACC/RSP).
- busy  output  1  high in ACC and RSP.

Behaviour:
- FSM states: IDLE, ACC, RSP.
- Each transaction takes exactly 3 cycles: IDLE (arbitrate), ACC (memory strobe), RSP (ack).
- Registered state: state, owner, rr_last, beat_cnt[3:0].
- Reset (asynchronous, immediate): state=IDLE, owner=0, rr_last=1, beat_cnt=0.
- All outputs are 0 during and directly after reset: acks, mem_en, mem_we, mem_byte, mem_addr, mem_wdata, busy.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master, go to ACC.
  - Both requesting, normal case: grant the master != rr_last.
  - Both requesting, lock override: if rr_last=1, m1_lock=1, m1_req=1 and beat_cnt<MAX_BURST, grant master 1 again.
  - Grant latches owner.
- ACC:
  - mem_en=1; mem_we/mem_byte/mem_addr/mem_wdata are the owner's inputs.
  - Unconditional transition to RSP.
- RSP:
  - mX_ack=1 for the owner only.
  - rr_last <= owner; go to IDLE.
- beat_cnt:
  - Updated at the RSP->IDLE transition.
  - Increments when owner=1 and m1_lock=1, saturating at 15.
  - Clears to 0 when owner=0 or m1_lock=0.
- Lock release: in IDLE, if m1_req=0, master 1 loses lock priority regardless of m1_lock.
- Outside ACC: mem_en=mem_we=mem_byte=0 and mem_addr=mem_wdata=0.
- mX_rdata is combinational routing: m0_rdata=mem_rdata when owner=0 in RSP, else 0; m1_rdata likewise for owner=1.
- Write acks return rdata with no defined meaning; masters ignore it.
- Requests must stay stable from assertion through ack. The arbiter never aborts a granted transaction, even if req drops mid-flight; ack still pulses.
- A master's req seen in the IDLE cycle after its ack is treated as a new transaction.
- Reset asserted in ACC or RSP: mem_we and ack deassert immediately, the transaction is lost, and the master reissues after reset release.
- Worst-case wait for master 0: (MAX_BURST+1) transactions × 3 cycles.

Test Plan:
- Single read: m0_req=1, m0_addr=0x10, mem_rdata=0xDEADBEEF.
  - Required: cycle1 IDLE; cycle2 mem_en=1, mem_addr=0x10, mem_we=0; cycle3 m0_ack=1, m0_rdata=0xDEADBEEF.
  - Required: m1_ack never asserts.
- Tie after reset: m0_req=m1_req=1 held for 4 transactions, lock=0.
  - Required: grant order 0,1,0,1; acks at cycles 3,6,9,12.
- Locked burst, MAX_BURST=4: m1_lock=1, m0_req and m1_req continuous.
  - Required: order 0,1,1,1,1,0,1; beat_cnt reaches 4 before the master-0 grant.
- Byte write: m1_we=1, m1_byte=1, m1_addr=0x23, m1_wdata=0x000000AB.
  - Required ACC cycle: mem_en=1, mem_we=1, mem_byte=1, mem_addr=0x23, mem_wdata=0xAB; m1_ack in next cycle.
- Reset mid-transaction: assert rst low during ACC of an m0 write.
  - Required: mem_we=0 immediately, no m0_ack.
  - Required after release: state IDLE, rr_last=1, and m0 is reserved first on a tie.
- Lock with idle master 1: m1_lock=1, m1_req=0, m0_req=1.
  - Required: m0 granted in first IDLE cycle, beat_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic          m0_byte;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic          m1_byte;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_lock;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic          mem_byte;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          owner;
  logic          busy;

  modport slave (
    input  m0_req, m0_we, m0_byte, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_byte, m1_addr, m1_wdata, m1_lock,
    input  mem_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
    output owner, busy
  );

  modport master (
    output m0_req, m0_we, m0_byte, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_byte, m1_addr, m1_wdata, m1_lock,
    output mem_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
    input  owner, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for a single-port data memory; every access is
// IDLE (arbitrate) -> ACC (memory strobe) -> RSP (ack), with a bounded master-1 lock.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RSP = 2'd2} state_t;

  state_t        state, state_n;
  logic          owner, owner_n;
  logic          rr_last, rr_last_n;
  logic [3:0]    beat_cnt, beat_n;
  logic          lock_hold;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr_last  <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_last  <= rr_last_n;
      beat_cnt <= beat_n;
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    rr_last_n = rr_last;
    beat_n    = beat_cnt;
    addr_sel  = owner ? bus.m1_addr  : bus.m0_addr;
    wdata_sel = owner ? bus.m1_wdata : bus.m0_wdata;

    bus.m0_ack    = 1'b0;
    bus.m1_ack    = 1'b0;
    bus.m0_rdata  = '0;
    bus.m1_rdata  = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_byte  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.owner     = owner;
    bus.busy      = (state != IDLE);

    // Master 1 keeps the bus on a tie only while it was last served, still
    // requests, and has not yet used up its burst allowance.
    lock_hold = rr_last && bus.m1_lock && bus.m1_req && (beat_cnt < 4'(MAX_BURST));

    case (state)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          owner_n = lock_hold ? 1'b1 : ~rr_last;
          state_n = ACC;
        end else if (bus.m0_req) begin
          owner_n = 1'b0;
          state_n = ACC;
        end else if (bus.m1_req) begin
          owner_n = 1'b1;
          state_n = ACC;
        end
      end
      ACC: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = owner ? bus.m1_we   : bus.m0_we;
        bus.mem_byte  = owner ? bus.m1_byte : bus.m0_byte;
        bus.mem_addr  = addr_sel;
        bus.mem_wdata = wdata_sel;
        state_n       = RSP;
      end
      RSP: begin
        bus.m0_ack   = ~owner;
        bus.m1_ack   = owner;
        bus.m0_rdata = owner ? '0 : bus.mem_rdata;
        bus.m1_rdata = owner ? bus.mem_rdata : '0;
        rr_last_n    = owner;
        if (owner && bus.m1_lock)
          beat_n = (beat_cnt == 4'hF) ? beat_cnt : beat_cnt + 4'd1;
        else
          beat_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, single read, tie round-robin, locked burst,
// byte write, reset mid-transaction and lock with an idle master 1.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_byte = 1'b0;
    bus.m0_addr = '0;  bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_byte = 1'b0;
    bus.m1_addr = '0;  bus.m1_wdata = '0; bus.m1_lock = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.m0_ack !== 1'b0) begin failures++; $display("FAIL reset_m0_ack got=%0b exp=0", bus.m0_ack); end
    checks++; if (bus.m1_ack !== 1'b0) begin failures++; $display("FAIL reset_m1_ack got=%0b exp=0", bus.m1_ack); end
    checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%0b exp=0", bus.mem_en); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", bus.mem_we); end
    checks++; if (bus.mem_byte !== 1'b0) begin failures++; $display("FAIL reset_mem_byte got=%0b exp=0", bus.mem_byte); end
    checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%0h exp=0", bus.mem_wdata); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%0b exp=0", bus.owner); end
    checks++; if (dut.rr_last !== 1'b1) begin failures++; $display("FAIL reset_rr_last got=%0b exp=1", dut.rr_last); end
    checks++; if (dut.beat_cnt !== 4'd0) begin failures++; $display("FAIL reset_beat_cnt got=%0d exp=0", dut.beat_cnt); end
    clear_inputs();
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0) begin failures++; $display("FAIL post_reset_idle busy=%0b mem_en=%0b exp=0,0", bus.busy, bus.mem_en); end
  endtask

  task automatic test_single_read();
    logic m1_seen;
    do_reset();
    m1_seen = 1'b0;
    bus.mem_rdata = 32'hDEADBEEF;
    bus.m0_addr = 32'h10;
    bus.m0_req = 1'b1;
    #1;
    checks++; if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL read_c1_idle mem_en=%0b busy=%0b exp=0,0", bus.mem_en, bus.busy); end
    m1_seen |= bus.m1_ack;
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b1) begin failures++; $display("FAIL read_c2_mem_en got=%0b exp=1", bus.mem_en); end
    checks++; if (bus.mem_addr !== 32'h10) begin failures++; $display("FAIL read_c2_addr got=%0h exp=10", bus.mem_addr); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL read_c2_we got=%0b exp=0", bus.mem_we); end
    checks++; if (bus.m0_ack !== 1'b0) begin failures++; $display("FAIL read_c2_ack got=%0b exp=0", bus.m0_ack); end
    m1_seen |= bus.m1_ack;
    @(negedge clk);
    checks++; if (bus.m0_ack !== 1'b1) begin failures++; $display("FAIL read_c3_ack got=%0b exp=1", bus.m0_ack); end
    checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL read_c3_rdata got=%0h exp=deadbeef", bus.m0_rdata); end
    checks++; if (bus.m1_rdata !== 32'h0) begin failures++; $display("FAIL read_c3_m1_rdata got=%0h exp=0", bus.m1_rdata); end
    checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL read_c3_mem_en got=%0b exp=0", bus.mem_en); end
    m1_seen |= bus.m1_ack;
    bus.m0_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.m0_ack !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL read_c4_done ack=%0b busy=%0b exp=0,0", bus.m0_ack, bus.busy); end
    m1_seen |= bus.m1_ack;
    checks++; if (m1_seen !== 1'b0) begin failures++; $display("FAIL read_m1_ack_seen got=%0b exp=0", m1_seen); end
  endtask

  task automatic test_tie();
    logic exp0, exp1, exp_own;
    do_reset();
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      #1;
      exp0 = (cyc == 3 || cyc == 9);
      exp1 = (cyc == 6 || cyc == 12);
      checks++; if (bus.m0_ack !== exp0) begin failures++; $display("FAIL tie_m0_ack cyc=%0d got=%0b exp=%0b", cyc, bus.m0_ack, exp0); end
      checks++; if (bus.m1_ack !== exp1) begin failures++; $display("FAIL tie_m1_ack cyc=%0d got=%0b exp=%0b", cyc, bus.m1_ack, exp1); end
      if (cyc % 3 == 2) begin
        exp_own = ((cyc / 3) % 2) == 1;
        checks++; if (bus.owner !== exp_own || bus.mem_en !== 1'b1) begin failures++; $display("FAIL tie_owner cyc=%0d got=%0b/%0b exp=%0b/1", cyc, bus.owner, bus.mem_en, exp_own); end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_locked_burst();
    logic order [7];
    logic exp_order [7];
    int   idx;
    exp_order = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    idx = 0;
    do_reset();
    bus.m0_req = 1'b1;
    @(negedge clk);
    bus.m1_req = 1'b1;
    bus.m1_lock = 1'b1;
    for (int cyc = 2; cyc <= 21; cyc++) begin
      #1;
      if (bus.mem_en === 1'b1 && idx < 7) begin
        order[idx] = bus.owner;
        if (idx == 5) begin
          checks++; if (dut.beat_cnt !== 4'd4) begin failures++; $display("FAIL burst_beat_cnt got=%0d exp=4", dut.beat_cnt); end
        end
        idx++;
      end
      @(negedge clk);
    end
    clear_inputs();
    checks++; if (idx !== 7) begin failures++; $display("FAIL burst_grant_count got=%0d exp=7", idx); end
    for (int i = 0; i < 7; i++) begin
      if (i < idx) begin
        checks++; if (order[i] !== exp_order[i]) begin failures++; $display("FAIL burst_order idx=%0d got=%0b exp=%0b", i, order[i], exp_order[i]); end
      end
    end
  endtask

  task automatic test_byte_write();
    do_reset();
    bus.m1_we = 1'b1;
    bus.m1_byte = 1'b1;
    bus.m1_addr = 32'h23;
    bus.m1_wdata = 32'h000000AB;
    bus.m1_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_byte !== 1'b1) begin failures++; $display("FAIL bw_strobes en/we/byte got=%0b%0b%0b exp=111", bus.mem_en, bus.mem_we, bus.mem_byte); end
    checks++; if (bus.mem_addr !== 32'h23) begin failures++; $display("FAIL bw_addr got=%0h exp=23", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'hAB) begin failures++; $display("FAIL bw_wdata got=%0h exp=ab", bus.mem_wdata); end
    checks++; if (bus.owner !== 1'b1) begin failures++; $display("FAIL bw_owner got=%0b exp=1", bus.owner); end
    @(negedge clk);
    checks++; if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0) begin failures++; $display("FAIL bw_ack m1/m0 got=%0b/%0b exp=1/0", bus.m1_ack, bus.m0_ack); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL bw_rsp_we got=%0b exp=0", bus.mem_we); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.m0_we = 1'b1;
    bus.m0_addr = 32'h40;
    bus.m0_wdata = 32'h1234;
    bus.m0_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL rmid_acc_we got=%0b exp=1", bus.mem_we); end
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_en !== 1'b0) begin failures++; $display("FAIL rmid_we_drop we=%0b en=%0b exp=0,0", bus.mem_we, bus.mem_en); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0b exp=0", bus.busy); end
    checks++; if (dut.rr_last !== 1'b1) begin failures++; $display("FAIL rmid_rr_last got=%0b exp=1", dut.rr_last); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.m0_ack !== 1'b0) begin failures++; $display("FAIL rmid_no_ack i=%0d got=%0b exp=0", i, bus.m0_ack); end
    end
    bus.m1_req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b1 || bus.owner !== 1'b0) begin failures++; $display("FAIL rmid_tie_grant en/owner got=%0b/%0b exp=1/0", bus.mem_en, bus.owner); end
    @(negedge clk);
    checks++; if (bus.m0_ack !== 1'b1) begin failures++; $display("FAIL rmid_reissue_ack got=%0b exp=1", bus.m0_ack); end
    clear_inputs();
  endtask

  task automatic test_lock_idle();
    do_reset();
    bus.m1_lock = 1'b1;
    bus.m0_req = 1'b1;
    #1;
    checks++; if (dut.beat_cnt !== 4'd0) begin failures++; $display("FAIL lidle_beat0 got=%0d exp=0", dut.beat_cnt); end
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b1 || bus.owner !== 1'b0) begin failures++; $display("FAIL lidle_grant en/owner got=%0b/%0b exp=1/0", bus.mem_en, bus.owner); end
    @(negedge clk);
    checks++; if (bus.m0_ack !== 1'b1) begin failures++; $display("FAIL lidle_ack got=%0b exp=1", bus.m0_ack); end
    bus.m0_req = 1'b0;
    @(negedge clk);
    checks++; if (dut.beat_cnt !== 4'd0) begin failures++; $display("FAIL lidle_beat_after got=%0d exp=0", dut.beat_cnt); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_locked_burst();
    test_byte_write();
    test_reset_mid();
    test_lock_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
